// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter: FSM state encoding and a
// constant-foldable ceil(log2) used to size index and hold-counter fields.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Requester/grant bundle between the upstream requesters and the arbiter.
// The arbiter takes the master side; upstream logic (or a bench) takes the slave side.
interface req_arbiter_if
  import arb_pkg::*;
#(
  parameter int N = 8
);
  localparam int IDXW = clog2(N);

  logic            enable;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  modport master (input enable, req, output gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (output enable, req, input gnt, gnt_idx, gnt_valid, timeout);

endinterface

// File: rtl/prio_pick.sv
// LSB-first priority encoder: index of the lowest set bit of req_vec, plus valid.
module prio_pick #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    req_vec,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        idx   = IDXW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// N-way request arbiter with hold timeout and a mandatory one-cycle release gap.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst,
  req_arbiter_if.master bus
);

  localparam int IDXW = clog2(N);
  localparam int HCW  = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [IDXW:0]  N_W       = (IDXW + 1)'(N);

  state_t          state_reg, state_next;
  logic [N-1:0]    gnt_reg, gnt_next;
  logic [IDXW-1:0] gnt_idx_reg, gnt_idx_next;
  logic            gnt_valid_reg, gnt_valid_next;
  logic            timeout_reg, timeout_next;
  logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;

  logic [N-1:0]    pick_in;
  logic [IDXW-1:0] pick_idx;
  logic            pick_valid;
  logic [IDXW-1:0] winner;
  logic            owner_req, hold_expired, grant_start;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDXW-1:0] rr_ptr_reg;
  logic [IDXW:0]   win_sum, nxt_sum;

  // Rotate so rr_ptr lands on bit 0, encode, then undo the rotation modulo N.
  assign pick_in = (bus.req >> rr_ptr_reg) | (bus.req << (N_W - {1'b0, rr_ptr_reg}));
  assign win_sum = {1'b0, pick_idx} + {1'b0, rr_ptr_reg};
  assign winner  = (win_sum >= N_W) ? IDXW'(win_sum - N_W) : win_sum[IDXW-1:0];
  assign nxt_sum = {1'b0, winner} + (IDXW + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_start) begin
      rr_ptr_reg <= (nxt_sum >= N_W) ? '0 : nxt_sum[IDXW-1:0];
    end
  end
`else
  assign pick_in = bus.req;
  assign winner  = pick_idx;
`endif

  prio_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .req_vec (pick_in),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  assign owner_req    = bus.req[gnt_idx_reg];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);
  assign grant_start  = (state_reg == ST_IDLE) && bus.enable && pick_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
      timeout_reg   <= timeout_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (grant_start) state_next = ST_GRANT;
      ST_GRANT:   if (!owner_req || hold_expired) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Owner drop is tested before expiry so a coincident drop never pulses timeout.
  always_comb begin
    gnt_next       = gnt_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
    timeout_next   = 1'b0;
    hold_cnt_next  = hold_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_start) begin
          gnt_next       = {{(N-1){1'b0}}, 1'b1} << winner;
          gnt_idx_next   = winner;
          gnt_valid_next = 1'b1;
          hold_cnt_next  = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || hold_expired) begin
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
          hold_cnt_next  = '0;
          timeout_next   = owner_req;
        end else if (hold_cnt_reg != '1) begin
          hold_cnt_next  = hold_cnt_reg + 1'b1;
        end
      end
      ST_RELEASE: begin
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        hold_cnt_next  = '0;
      end
      default: begin
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        hold_cnt_next  = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_idx   = gnt_idx_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.timeout   = timeout_reg;

endmodule
